// File: rtl/sram_burst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_burst_pkg
// Description : Shared types and constants for the single-port SRAM burst
//               controller: FSM state encoding and read-buffer geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_burst_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Read buffer absorbs the one-cycle SRAM latency plus two words of slack
    localparam int RBUF_DEPTH = 3;
    localparam int RBUF_PTR_W = 2;
    localparam int RBUF_OCC_W = 2;

    // Modulo-RBUF_DEPTH pointer increment
    function automatic logic [RBUF_PTR_W-1:0] rbuf_ptr_inc(input logic [RBUF_PTR_W-1:0] ptr);
        return (ptr == RBUF_PTR_W'(RBUF_DEPTH - 1)) ? '0 : ptr + RBUF_PTR_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_burst_rbuf.sv
`default_nettype none
// ============================================================================
// Module      : sram_burst_rbuf
// Description : 3-entry synchronous FIFO holding {last, data} read words
//               between the SRAM and the read-data stream. Push and pop in
//               the same cycle are allowed at any occupancy; the controller
//               never pushes while the buffer is full.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_burst_rbuf
    import sram_burst_pkg::*;
#(
    parameter int W = 33
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [W-1:0]          push_data,
    input  logic                  pop,
    output logic [W-1:0]          pop_data,
    output logic [RBUF_OCC_W-1:0] occ
);

    logic [W-1:0]          mem [RBUF_DEPTH];
    logic [RBUF_PTR_W-1:0] wr_ptr;
    logic [RBUF_PTR_W-1:0] rd_ptr;
    logic                  do_pop;

    // A pop on an empty buffer is ignored so the pointers never slip
    assign do_pop = pop && (occ != '0);

    // Pointer and occupancy bookkeeping; reset flushes the buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= rbuf_ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= rbuf_ptr_inc(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   occ <= occ + RBUF_OCC_W'(1);
                2'b01:   occ <= occ - RBUF_OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage array; contents are only observed while occ is non-zero
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/sram_sp_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_sp_burst_ctrl
// Description : Burst initiator for a single-port SRAM with a registered
//               read port. Accepts read/write bursts on a valid/ready
//               command channel, streams write data in and read data out,
//               and hides the SRAM read latency behind a 3-entry buffer.
//               Optional feature macro: OPTIMSOC_SRAM_BURST_BOUNDS_EN
//               (aborts bursts running past MEM_SIZE_BYTE and pulses err).
// Revision    : 1.0 - initial release
// ============================================================================
module sram_sp_burst_ctrl
    import sram_burst_pkg::*;
#(
    parameter int          AW            = 32,
    parameter int          DW            = 32,
    parameter int          WORD_AW       = AW - ((DW / 8) >> 1),
    parameter int          LENW          = 8,
    parameter logic [63:0] MEM_SIZE_BYTE = 'x
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [WORD_AW-1:0]   req_waddr,
    input  logic [LENW-1:0]      req_len,

    input  logic                 wdata_valid,
    output logic                 wdata_ready,
    input  logic [DW-1:0]        wdata,
    input  logic [DW/8-1:0]      wsel,

    output logic                 rdata_valid,
    input  logic                 rdata_ready,
    output logic [DW-1:0]        rdata,
    output logic                 rdata_last,

    output logic                 err,

    output logic                 sram_ce,
    output logic                 sram_we,
    output logic                 sram_oe,
    output logic [WORD_AW-1:0]   sram_waddr,
    output logic [DW-1:0]        sram_din,
    output logic [DW/8-1:0]      sram_sel,
    input  logic [DW-1:0]        sram_dout
);

    localparam int SW = DW / 8;

    state_t                  state_q;
    state_t                  state_n;
    logic                    ready_q;
    logic [WORD_AW-1:0]      addr_q;
    logic [LENW-1:0]         cnt_q;
    logic                    rd_pending_q;  // a read was issued last cycle
    logic                    rd_last_q;     // ... and it was the burst's final word
    logic                    abort_q;       // current burst has SRAM accesses suppressed
    logic                    err_q;

    logic                    accept;
    logic                    oob;
    logic                    issue_rd;
    logic                    wr_beat;

    logic                    buf_push;
    logic [DW:0]             buf_push_data;
    logic                    buf_pop;
    logic [DW:0]             buf_head;
    logic [RBUF_OCC_W-1:0]   buf_occ;
    logic [2:0]              rd_inflight;
    logic                    rd_room;

    assign accept = req_valid && ready_q;

`ifdef OPTIMSOC_SRAM_BURST_BOUNDS_EN
    // End-of-burst address computed wide enough that it can never wrap
    localparam int SUMW = WORD_AW + LENW + 1;
    logic [SUMW-1:0] burst_end;
    assign burst_end = SUMW'(req_waddr) + SUMW'(req_len);
    assign oob       = (burst_end >= SUMW'(MEM_SIZE_BYTE / SW));
`else
    // Without the bounds check addresses simply wrap and err stays low
    logic unused_mem_size;
    assign oob             = 1'b0;
    assign unused_mem_size = ^MEM_SIZE_BYTE;
`endif

    // Words issued to the SRAM but not yet consumed downstream; only
    // registered terms, so rdata_ready never reaches sram_ce combinationally
    assign rd_inflight = {1'b0, buf_occ} + {2'b00, rd_pending_q};
    assign rd_room     = (rd_inflight < 3'(RBUF_DEPTH));

    // Next-state and SRAM port drive; all SRAM outputs idle at zero
    always_comb begin
        state_n     = state_q;
        issue_rd    = 1'b0;
        wr_beat     = 1'b0;
        wdata_ready = 1'b0;
        sram_ce     = 1'b0;
        sram_we     = 1'b0;
        sram_oe     = 1'b0;
        sram_waddr  = '0;
        sram_din    = '0;
        sram_sel    = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_n = req_we ? WRITE : READ;
                end
            end
            WRITE: begin
                wdata_ready = 1'b1;
                if (wdata_valid) begin
                    wr_beat = 1'b1;
                    if (!abort_q) begin
                        sram_ce    = 1'b1;
                        sram_we    = 1'b1;
                        sram_waddr = addr_q;
                        sram_din   = wdata;
                        sram_sel   = wsel;
                    end
                    if (cnt_q == '0) begin
                        state_n = IDLE;
                    end
                end
            end
            READ: begin
                if (rd_room) begin
                    issue_rd = 1'b1;
                    if (!abort_q) begin
                        sram_ce    = 1'b1;
                        sram_oe    = 1'b1;
                        sram_waddr = addr_q;
                        sram_sel   = '1;
                    end
                    if (cnt_q == '0) begin
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((buf_occ == '0) && !rd_pending_q) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, burst address/length and read pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ready_q      <= 1'b0;
            addr_q       <= '0;
            cnt_q        <= '0;
            rd_pending_q <= 1'b0;
            rd_last_q    <= 1'b0;
            abort_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_n;
            ready_q      <= (state_n == IDLE);
            err_q        <= accept && oob;
            rd_pending_q <= issue_rd;
            rd_last_q    <= issue_rd && (cnt_q == '0);
            if (accept) begin
                addr_q  <= req_waddr;
                cnt_q   <= req_len;
                abort_q <= oob;
            end else if (wr_beat || issue_rd) begin
                addr_q <= addr_q + WORD_AW'(1);
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - LENW'(1);
                end
            end
        end
    end

    // Capture the SRAM word one cycle after its issue; aborted bursts return zeros
    assign buf_push      = rd_pending_q;
    assign buf_push_data = {rd_last_q, (abort_q ? {DW{1'b0}} : sram_dout)};
    assign buf_pop       = rdata_valid && rdata_ready;

    sram_burst_rbuf #(
        .W (DW + 1)
    ) u_rbuf (
        .clk       (clk),
        .rst       (rst),
        .push      (buf_push),
        .push_data (buf_push_data),
        .pop       (buf_pop),
        .pop_data  (buf_head),
        .occ       (buf_occ)
    );

    assign req_ready   = ready_q;
    assign err         = err_q;
    assign rdata_valid = (buf_occ != '0);
    assign rdata       = rdata_valid ? buf_head[DW-1:0] : '0;
    assign rdata_last  = rdata_valid && buf_head[DW];

endmodule
`default_nettype wire
